// File: rtl/universal_shift_register.sv
// Universal shift register: parallel load, five single-step shift/rotate
// modes, serial-out taps at both ends, and an autonomous burst controller
// that runs a programmed number of steps with a busy/done handshake.
module universal_shift_register #(
  parameter int N  = 32,
  parameter int CW = 6
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic [N-1:0]  r,
  input  logic          l,
  input  logic          e,
  input  logic [2:0]    mode,
  input  logic          wr,
  input  logic          wl,
  input  logic          start,
  input  logic [CW-1:0] count,
  output logic [N-1:0]  q,
  output logic          sout_r,
  output logic          sout_l,
  output logic          busy,
  output logic          done
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0] CNT_ZERO = '0;

  state_t        state_q, state_d;
  logic [N-1:0]  q_q, q_d;
  logic          sout_r_q, sout_r_d;
  logic          sout_l_q, sout_l_d;
  logic [2:0]    burst_mode_q, burst_mode_d;
  logic [CW-1:0] remaining_q, remaining_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;

  // One step of the selected mode. Returns {new_q, new_sout_r, new_sout_l};
  // the tap on the side that did not shift keeps its old value, and the
  // reserved modes hold everything.
  function automatic logic [N+1:0] step(
    input logic [2:0]   m,
    input logic [N-1:0] cur,
    input logic         tap_r,
    input logic         tap_l,
    input logic         in_r,
    input logic         in_l
  );
    logic [N-1:0] nq;
    logic         nr;
    logic         nl;
    nq = cur;
    nr = tap_r;
    nl = tap_l;
    case (m)
      3'b000: begin nq = {in_r,     cur[N-1:1]}; nr = cur[0];   end
      3'b001: begin nq = {cur[N-2:0], in_l};     nl = cur[N-1]; end
      3'b010: begin nq = {cur[0],   cur[N-1:1]}; nr = cur[0];   end
      3'b011: begin nq = {cur[N-2:0], cur[N-1]}; nl = cur[N-1]; end
      3'b100: begin nq = {cur[N-1], cur[N-1:1]}; nr = cur[0];   end
      default: ;
    endcase
    return {nq, nr, nl};
  endfunction

  // State and datapath registers.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= S_IDLE;
      q_q          <= '0;
      sout_r_q     <= 1'b0;
      sout_l_q     <= 1'b0;
      burst_mode_q <= 3'b000;
      remaining_q  <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      q_q          <= q_d;
      sout_r_q     <= sout_r_d;
      sout_l_q     <= sout_l_d;
      burst_mode_q <= burst_mode_d;
      remaining_q  <= remaining_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  // Next state and datapath: load beats a burst step, which beats start,
  // which beats a single-step enable.
  always_comb begin
    // NOTE: every target gets a hold default first so no path infers a latch.
    state_d      = state_q;
    q_d          = q_q;
    sout_r_d     = sout_r_q;
    sout_l_d     = sout_l_q;
    burst_mode_d = burst_mode_q;
    remaining_d  = remaining_q;
    case (state_q)
      S_IDLE: begin
        if (l) begin
          q_d = r;
        end else if (start && (count != CNT_ZERO)) begin
          burst_mode_d = mode;
          remaining_d  = count;
          state_d      = S_SHIFT;
        end else if (start) begin
          state_d = S_DONE;
        end else if (e) begin
          {q_d, sout_r_d, sout_l_d} = step(mode, q_q, sout_r_q, sout_l_q, wr, wl);
        end
      end
      S_SHIFT: begin
        if (l) begin
          // Abort: load wins, burst is dropped without a done pulse.
          q_d         = r;
          remaining_d = '0;
          state_d     = S_IDLE;
        end else begin
          {q_d, sout_r_d, sout_l_d} = step(burst_mode_q, q_q, sout_r_q, sout_l_q, wr, wl);
          remaining_d = remaining_q - CNT_ONE;
          if (remaining_q == CNT_ONE) state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (l) q_d = r;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Handshake outputs decoded from the next state so they are registered
  // and line up with the state they describe.
  always_comb begin
    busy_d = (state_d == S_SHIFT);
    done_d = (state_d == S_DONE);
  end

  assign q      = q_q;
  assign sout_r = sout_r_q;
  assign sout_l = sout_l_q;
  assign busy   = busy_q;
  assign done   = done_q;

endmodule

// File: tb/tb_universal_shift_register.sv
// Self-checking bench for universal_shift_register at N=8: a table of
// single-cycle idle operations, then hand-written burst sequences.
module tb_universal_shift_register;

  localparam int N  = 8;
  localparam int CW = 6;

  logic          clk = 1'b0;
  logic          resetn;
  logic [N-1:0]  r;
  logic          l, e, wr, wl, start;
  logic [2:0]    mode;
  logic [CW-1:0] count;
  logic [N-1:0]  q;
  logic          sout_r, sout_l, busy, done;

  int checks = 0;
  int errors = 0;

  universal_shift_register #(.N(N), .CW(CW)) dut (
    .clk   (clk),
    .resetn(resetn),
    .r     (r),
    .l     (l),
    .e     (e),
    .mode  (mode),
    .wr    (wr),
    .wl    (wl),
    .start (start),
    .count (count),
    .q     (q),
    .sout_r(sout_r),
    .sout_l(sout_l),
    .busy  (busy),
    .done  (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       l;
    logic       e;
    logic [2:0] mode;
    logic       wr;
    logic       wl;
    logic [7:0] r;
    logic [7:0] exp_q;
    logic       exp_sr;
    logic       exp_sl;
  } vec_t;

  vec_t vecs[13];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    l = 0; e = 0; start = 0; mode = 3'b000; wr = 0; wl = 0; r = '0; count = '0;
  endtask

  task automatic load(input logic [7:0] val);
    l = 1; r = val;
    tick();
    l = 0;
    check("load_q", q, val);
  endtask

  initial begin
    idle_inputs();
    resetn = 0;
    #12;
    check("reset_q", q, 8'h00);
    check("reset_sout_r", sout_r, 0);
    check("reset_sout_l", sout_l, 0);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    resetn = 1;
    tick();

    // Single-cycle idle operations: {l,e,mode,wr,wl,r, q,sout_r,sout_l}
    vecs[0]  = '{1, 0, 3'b000, 0, 0, 8'hA5, 8'hA5, 0, 0}; // load
    vecs[1]  = '{0, 1, 3'b000, 0, 0, 8'h00, 8'h52, 1, 0}; // SRL wr=0
    vecs[2]  = '{0, 1, 3'b001, 0, 1, 8'h00, 8'hA5, 1, 0}; // SLL wl=1
    vecs[3]  = '{0, 1, 3'b010, 0, 0, 8'h00, 8'hD2, 1, 0}; // ROR
    vecs[4]  = '{0, 1, 3'b011, 0, 0, 8'h00, 8'hA5, 1, 1}; // ROL
    vecs[5]  = '{0, 1, 3'b100, 0, 0, 8'h00, 8'hD2, 1, 1}; // SRA
    vecs[6]  = '{0, 1, 3'b101, 1, 1, 8'h00, 8'hD2, 1, 1}; // reserved: hold
    vecs[7]  = '{0, 0, 3'b000, 1, 1, 8'h00, 8'hD2, 1, 1}; // e=0: hold
    vecs[8]  = '{1, 1, 3'b000, 1, 0, 8'hB4, 8'hB4, 1, 1}; // load beats e
    vecs[9]  = '{0, 1, 3'b000, 1, 0, 8'h00, 8'hDA, 0, 1}; // SRL wr=1
    vecs[10] = '{0, 1, 3'b000, 1, 0, 8'h00, 8'hED, 0, 1}; // SRL wr=1
    vecs[11] = '{1, 0, 3'b111, 0, 0, 8'h00, 8'h00, 0, 1}; // load zero
    vecs[12] = '{0, 1, 3'b011, 0, 0, 8'h00, 8'h00, 0, 0}; // ROL clears tap

    for (int i = 0; i < 13; i++) begin
      l = vecs[i].l; e = vecs[i].e; mode = vecs[i].mode;
      wr = vecs[i].wr; wl = vecs[i].wl; r = vecs[i].r;
      tick();
      check($sformatf("vec%0d_q", i), q, vecs[i].exp_q);
      check($sformatf("vec%0d_sout_r", i), sout_r, vecs[i].exp_sr);
      check($sformatf("vec%0d_sout_l", i), sout_l, vecs[i].exp_sl);
      check($sformatf("vec%0d_busy", i), busy, 0);
      check($sformatf("vec%0d_done", i), done, 0);
    end
    idle_inputs();

    // ROL burst of 3 from 0x81
    load(8'h81);
    mode = 3'b011; start = 1; count = 3;
    tick();
    start = 0;
    check("rol_accept_q", q, 8'h81);
    check("rol_accept_busy", busy, 1);
    tick();
    check("rol_s1_q", q, 8'h03);
    check("rol_s1_sout_l", sout_l, 1);
    check("rol_s1_busy", busy, 1);
    tick();
    check("rol_s2_q", q, 8'h06);
    check("rol_s2_busy", busy, 1);
    tick();
    check("rol_s3_q", q, 8'h0C);
    check("rol_s3_sout_l", sout_l, 0);
    check("rol_s3_busy", busy, 0);
    check("rol_s3_done", done, 1);
    tick();
    check("rol_after_done", done, 0);
    check("rol_after_busy", busy, 0);

    // SRA burst of 2 from 0x90, mode and e disturbed mid-burst
    load(8'h90);
    mode = 3'b100; start = 1; count = 2;
    tick();
    start = 0; mode = 3'b001; e = 1; wl = 1;
    tick();
    check("sra_s1_q", q, 8'hC8);
    tick();
    e = 0;
    check("sra_s2_q", q, 8'hE4);
    check("sra_s2_sout_r", sout_r, 0);
    check("sra_s2_done", done, 1);
    check("sra_s2_busy", busy, 0);
    tick();
    check("sra_after_q", q, 8'hE4);
    check("sra_after_done", done, 0);
    idle_inputs();

    // Zero-length burst: done on the cycle after the start edge, no shift
    mode = 3'b000; wr = 1; start = 1; count = 0;
    tick();
    start = 0;
    check("zero_done", done, 1);
    check("zero_busy", busy, 0);
    check("zero_q", q, 8'hE4);
    tick();
    check("zero_after_done", done, 0);
    check("zero_after_q", q, 8'hE4);
    idle_inputs();

    // ROR burst of 10 from 0x01, aborted by load after 4 shifts
    load(8'h01);
    mode = 3'b010; start = 1; count = 10;
    tick();
    start = 0;
    tick(); check("ror_s1_q", q, 8'h80);
    tick(); check("ror_s2_q", q, 8'h40);
    tick(); check("ror_s3_q", q, 8'h20);
    tick(); check("ror_s4_q", q, 8'h10);
    check("ror_s4_busy", busy, 1);
    l = 1; r = 8'h3C;
    tick();
    l = 0;
    check("abort_q", q, 8'h3C);
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    for (int i = 0; i < 12; i++) begin
      tick();
      check($sformatf("abort_idle%0d_done", i), done, 0);
      check($sformatf("abort_idle%0d_q", i), q, 8'h3C);
    end
    idle_inputs();

    // Asynchronous reset mid-burst (reserved mode keeps q at 0xA5)
    load(8'hA5);
    mode = 3'b101; start = 1; count = 5;
    tick();
    start = 0;
    tick();
    check("mid_busy", busy, 1);
    check("mid_q", q, 8'hA5);
    #3;
    resetn = 0;
    #1;
    check("async_rst_q", q, 8'h00);
    check("async_rst_busy", busy, 0);
    check("async_rst_done", done, 0);
    tick();
    resetn = 1;
    for (int i = 0; i < 8; i++) begin
      tick();
      check($sformatf("post_rst%0d_done", i), done, 0);
      check($sformatf("post_rst%0d_busy", i), busy, 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
